// File: rtl/rx_frame_sync_if.sv
// Bit-stream input and deframed byte-stream output of the frame synchroniser.
// The master drives recovered bits; the slave (the synchroniser) drives bytes and status.
interface rx_frame_sync_if;
  logic        bit_in;
  logic        bit_valid;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tuser;
  logic        data_tlast;
  logic        locked;
  logic        inverted;
  logic [15:0] frame_cnt;

  modport master (
    output bit_in, bit_valid,
    input  data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, frame_cnt
  );

  modport slave (
    input  bit_in, bit_valid,
    output data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, frame_cnt
  );
endinterface

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: hunts an error-tolerant sync word in either polarity, then deframes
// FRAME_BYTES payload bytes MSB-first; each byte appears one cycle after its 8th bit strobe.
module rx_frame_sync #(
  parameter int                  SYNC_LEN    = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hEB90,
  parameter int                  FRAME_BYTES = 8,
  parameter int                  MAX_ERR     = 1
) (
  input logic            clk_32M768,
  input logic            rst_32M768,
  rx_frame_sync_if.slave bus
);

  localparam int FW = $clog2(SYNC_LEN + 1);

  typedef enum logic {HUNT, PAYLOAD} state_e;

  state_e              state_q, state_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d, sr_shift;
  logic [FW-1:0]       fill_q, fill_d, fill_inc;
  logic                inv_q, inv_d;
  logic [7:0]          byte_q, byte_d, byte_shift;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                tvalid_q, tvalid_d;
  logic [7:0]          tdata_q, tdata_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;
  int                  err_true, err_inv;

  function automatic int popcnt(input logic [SYNC_LEN-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < SYNC_LEN; k++) n += int'(v[k]);
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    inv_d       = inv_q;
    byte_d      = byte_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    tvalid_d    = 1'b0;
    tdata_d     = '0;
    tuser_d     = 1'b0;
    tlast_d     = 1'b0;

    // Correlation looks at the window including the bit arriving this cycle.
    sr_shift   = (sr_q << 1) | SYNC_LEN'(bus.bit_in);
    fill_inc   = (fill_q == FW'(SYNC_LEN)) ? fill_q : fill_q + FW'(1);
    err_true   = popcnt(sr_shift ^ SYNC_WORD);
    err_inv    = popcnt(sr_shift ^ ~SYNC_WORD);
    byte_shift = (byte_q << 1) | 8'(bus.bit_in ^ inv_q);

    if (bus.bit_valid) begin
      case (state_q)
        HUNT: begin
          sr_d   = sr_shift;
          fill_d = fill_inc;
          if (fill_inc == FW'(SYNC_LEN) && (err_true <= MAX_ERR || err_inv <= MAX_ERR)) begin
            state_d    = PAYLOAD;
            inv_d      = !(err_true <= MAX_ERR);
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            byte_d     = '0;
          end
        end
        PAYLOAD: begin
          byte_d    = byte_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tvalid_d   = 1'b1;
            tdata_d    = byte_shift;
            tuser_d    = (byte_cnt_q == 8'd0);
            tlast_d    = (byte_cnt_q == 8'(FRAME_BYTES - 1));
            byte_cnt_d = byte_cnt_q + 8'd1;
            // Clearing the fill count forces a full fresh sync word, so payload cannot relock.
            if (byte_cnt_q == 8'(FRAME_BYTES - 1)) begin
              state_d     = HUNT;
              sr_d        = '0;
              fill_d      = '0;
              byte_cnt_d  = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      inv_q       <= 1'b0;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      inv_q       <= inv_d;
      byte_q      <= byte_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign bus.data_tdata  = tdata_q;
  assign bus.data_tvalid = tvalid_q;
  assign bus.data_tuser  = tuser_q;
  assign bus.data_tlast  = tlast_q;
  assign bus.locked      = (state_q == PAYLOAD);
  assign bus.inverted    = inv_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: bit streams are scored by a window-scanning reference model;
// a negedge monitor pops expected bytes whenever the DUT presents tvalid.
module tb_rx_frame_sync;
  localparam logic [15:0] SYNC = 16'hEB90;

  typedef struct {
    logic [7:0]  data;
    logic        user;
    logic        last;
    logic        inv;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_sync_if bus ();
  rx_frame_sync dut (.clk_32M768(clk), .rst_32M768(rst), .bus(bus));

  exp_t exp_q[$];
  bit   bits[$];
  bit   exp_lock[$];
  int   m_fc;
  int   total = 0, bad = 0;
  int   n_bytes, n_user, n_last;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected byte per tvalid pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst) begin
      if (bus.data_tvalid) begin
        n_bytes++;
        if (bus.data_tuser) n_user++;
        if (bus.data_tlast) n_last++;
        if (exp_q.size() == 0) check("tvalid_unexpected", bus.data_tvalid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("tdata", bus.data_tdata, e.data);
          check("tuser", bus.data_tuser, e.user);
          check("tlast", bus.data_tlast, e.last);
          check("inverted", bus.inverted, e.inv);
          check("frame_cnt", bus.frame_cnt, e.fc);
        end
      end else begin
        check("idle_outputs_zero", {bus.data_tdata, bus.data_tuser, bus.data_tlast}, '0);
      end
    end
  end

  // Reference model: scan 16-bit windows for a match within one bit error in either
  // polarity; a match consumes the next 64 bits as payload, then hunting restarts fresh.
  task automatic model_run();
    int i, start, idx;
    logic [15:0] w;
    logic [7:0] by;
    bit inv, hit;
    exp_t e;
    exp_lock.delete();
    i = 0;
    start = 0;
    while (i < bits.size()) begin
      hit = 1'b0;
      inv = 1'b0;
      if (i - start >= 15) begin
        w = '0;
        for (int k = i - 15; k <= i; k++) w = {w[14:0], bits[k]};
        if ($countones(w ^ SYNC) <= 1) hit = 1'b1;
        else if ($countones(w ^ ~SYNC) <= 1) begin hit = 1'b1; inv = 1'b1; end
      end
      exp_lock.push_back(hit);
      if (!hit) i++;
      else begin
        by = '0;
        for (int p = 0; p < 64 && i + 1 + p < bits.size(); p++) begin
          idx = i + 1 + p;
          by = {by[6:0], bits[idx] ^ inv};
          exp_lock.push_back(p != 63);
          if (p % 8 == 7) begin
            e.data = by;
            e.user = (p == 7);
            e.last = (p == 63);
            e.inv  = inv;
            e.fc   = 16'(m_fc + ((p == 63) ? 1 : 0));
            exp_q.push_back(e);
            if (p == 63) m_fc++;
          end
        end
        i += 65;
        start = i;
      end
    end
  endtask

  function automatic bit any_match();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < bits.size(); i++) begin
      w = {w[14:0], bits[i]};
      if (i >= 15 && ($countones(w ^ SYNC) <= 1 || $countones(w ^ ~SYNC) <= 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_word(input logic [15:0] w);
    for (int k = 15; k >= 0; k--) bits.push_back(w[k]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
  endtask

  task automatic push_frame(input logic [15:0] sw, input logic [7:0] base, input bit neg);
    push_word(sw);
    for (int k = 0; k < 8; k++) push_byte(neg ? ~(base + 8'(k)) : base + 8'(k));
  endtask

  task automatic send_bit(input bit b, input int gap);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  // gap <= 0 selects a random spacing of 1..3 cycles per bit.
  task automatic drive(input int gap);
    int g;
    for (int i = 0; i < bits.size(); i++) begin
      g = (gap > 0) ? gap : int'($urandom_range(1, 3));
      send_bit(bits[i], g);
      check("locked", bus.locked, exp_lock[i]);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("expected_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst     = 1'b0;
    m_fc    = 0;
    n_bytes = 0;
    n_user  = 0;
    n_last  = 0;
    exp_q.delete();
    bits.delete();
    mon_en  = 1'b1;
  endtask

  task automatic run(input int gap);
    model_run();
    drive(gap);
  endtask

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    do_reset();
    check("reset_tvalid", bus.data_tvalid, 1'b0);
    check("reset_locked", bus.locked, 1'b0);
    check("reset_inverted", bus.inverted, 1'b0);
    check("reset_frame_cnt", bus.frame_cnt, 16'd0);

    // Plain frame, sparse strobes
    push_frame(16'hEB90, 8'h01, 1'b0);
    run(32);
    check("t1_bytes", n_bytes, 8);
    check("t1_user", n_user, 1);
    check("t1_last", n_last, 1);
    check("t1_frame_cnt", bus.frame_cnt, 16'd1);
    check("t1_inverted", bus.inverted, 1'b0);

    // Fully inverted stream
    do_reset();
    push_frame(16'h146F, 8'h01, 1'b1);
    run(0);
    check("t2_inverted", bus.inverted, 1'b1);
    check("t2_frame_cnt", bus.frame_cnt, 16'd1);

    // One bit error tolerated, two rejected
    do_reset();
    push_frame(16'hEB91, 8'h01, 1'b0);
    run(0);
    check("t3a_bytes", n_bytes, 8);
    check("t3a_frame_cnt", bus.frame_cnt, 16'd1);
    do_reset();
    push_frame(16'hEB93, 8'h01, 1'b0);
    run(0);
    check("t3b_bytes", n_bytes, 0);
    check("t3b_locked", bus.locked, 1'b0);
    check("t3b_frame_cnt", bus.frame_cnt, 16'd0);

    // Random preamble without a sync match, then a random-payload frame
    do_reset();
    for (int a = 0; a < 30; a++) begin
      bits.delete();
      for (int k = 0; k < 200; k++) bits.push_back(1'($urandom_range(0, 1)));
      if (!any_match()) break;
    end
    push_frame(16'hEB90, 8'($urandom), 1'b0);
    run(0);
    check("t4a_frame_cnt", bus.frame_cnt, 16'd1);
    check("t4a_user", n_user, 1);

    // Two frames back-to-back at full bit rate
    do_reset();
    push_frame(16'hEB90, 8'h01, 1'b0);
    push_frame(16'hEB90, 8'h11, 1'b0);
    run(1);
    check("t4b_bytes", n_bytes, 16);
    check("t4b_user", n_user, 2);
    check("t4b_last", n_last, 2);
    check("t4b_frame_cnt", bus.frame_cnt, 16'd2);

    // Reset in the middle of an inverted frame
    do_reset();
    push_word(~SYNC);
    for (int k = 0; k < 3; k++) push_byte(~(8'h01 + 8'(k)));
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    run(0);
    check("t5_locked_before", bus.locked, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_tvalid", bus.data_tvalid, 1'b0);
    check("t5_tlast", bus.data_tlast, 1'b0);
    check("t5_tdata", bus.data_tdata, 8'h00);
    check("t5_locked", bus.locked, 1'b0);
    check("t5_inverted", bus.inverted, 1'b0);
    check("t5_frame_cnt", bus.frame_cnt, 16'd0);
    check("t5_last_seen", n_last, 0);
    do_reset();
    push_frame(16'hEB90, 8'h21, 1'b0);
    run(0);
    check("t5_after_frame_cnt", bus.frame_cnt, 16'd1);

    // Sync pattern inside payload must not relock or split the frame
    do_reset();
    push_word(SYNC);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'hEB); push_byte(8'h90);
    push_byte(8'h05); push_byte(8'h06); push_byte(8'h07); push_byte(8'h08);
    run(0);
    check("t6_bytes", n_bytes, 8);
    check("t6_last", n_last, 1);
    check("t6_frame_cnt", bus.frame_cnt, 16'd1);
    check("t6_locked", bus.locked, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
Frame synchroniser and byte deframer downstream of the receiver's serial bit output (Rx_1bit / Rx_valid). It hunts for a sync word in the recovered bit stream, tolerating a programmable number of bit errors. It also detects the BPSK 180° phase ambiguity through inverted-word correlation. Once locked, it emits a fixed-length payload as an AXI-Stream-style byte stream (tdata/tvalid/tuser/tlast) for the host-side data path.

Parameters:
SYNC_WORD, 16'hEB90, sync pattern, compared MSB-first.
SYNC_LEN, 16, sync word length in bits (8..32).
FRAME_BYTES, 8, payload bytes per frame after the sync word (1..255).
MAX_ERR, 1, maximum Hamming distance accepted as a match; must be < SYNC_LEN/2.

Ports:
clk_32M768  input  1  system clock; single clock domain.
rst_32M768  input  1  synchronous, active-high reset.
bit_in  input  1  recovered bit, sampled only when bit_valid=1.
bit_valid  input  1  one-cycle strobe per received bit; never asserted on consecutive cycles is NOT assumed, back-to-back strobes are legal.
data_tdata  output  8  payload byte, MSB = first received bit.
data_tvalid  output  1  one-cycle pulse per byte; no backpressure.
data_tuser  output  1  high with tvalid on the first byte of a frame.
data_tlast  output  1  high with tvalid on byte FRAME_BYTES-1.
locked  output  1  high while in PAYLOAD state.
inverted  output  1  polarity of the current or last lock; 1 means the inverted sync word matched.
frame_cnt  output  16  completed frames, wraps 16'hFFFF->0.

Behaviour:
- Reset (synchronous, dominant over all other events): state=HUNT; shift register, fill counter, bit and byte counters = 0; all outputs 0.
- Shift register sr[SYNC_LEN-1:0]: on bit_valid in HUNT, sr <= {sr[SYNC_LEN-2:0], bit_in}; fill counter saturates at SYNC_LEN.
- HUNT correlation uses the updated sr value, i.e. including the current bit, and is evaluated combinationally on the bit_valid cycle:
  - d = popcount(sr_next ^ SYNC_WORD); di = popcount(sr_next ^ ~SYNC_WORD).
  - Match requires fill_next == SYNC_LEN.
  - If d <= MAX_ERR: go to PAYLOAD, inverted<=0. Else if di <= MAX_ERR: go to PAYLOAD, inverted<=1. Non-inverted has priority.
  - State, locked and inverted update on the next clock edge (1-cycle latency from the last sync bit's strobe).
- PAYLOAD: on each bit_valid, b = bit_in ^ inverted is shifted into the byte register MSB-first and bit_cnt increments.
  - On the strobe carrying bit 8: data_tdata = the completed byte and data_tvalid=1, both registered, on the following cycle for exactly one cycle.
  - data_tuser=1 iff byte_cnt==0.
  - data_tlast=1 iff byte_cnt==FRAME_BYTES-1.
  - bit_cnt wraps to 0 and byte_cnt increments.
- End of frame: on the cycle tlast is emitted, frame_cnt increments, state returns to HUNT, and sr and the fill counter clear.
  - A new sync word needs SYNC_LEN fresh bits, so payload bits can never retrigger lock.
  - Back-to-back frames are supported: the first bit of the next sync word may arrive on the strobe immediately after the last payload bit.
- tuser, tlast and tdata are 0 whenever tvalid=0.
- Reset mid-frame: the partial frame is discarded; no tvalid or tlast is emitted and frame_cnt is unchanged.
- bit_valid=0: no state change, apart from the one-cycle output pulse clearing.
- No timeout: PAYLOAD always runs to FRAME_BYTES bytes.

Test Plan:
1. Bits of 16'hEB90 then bytes 01..08, bit_valid every 32 cycles -> 8 tvalid pulses with data 01..08; tuser on 01 only; tlast on 08 only; locked high from 1 cycle after the last sync strobe; frame_cnt=1; inverted=0.
2. All bits inverted (16'h146F, bytes FE..F7) -> output 01..08; inverted=1; frame_cnt=1.
3. Sync word with 1 bit flipped (16'hEB91) -> locks with the same output as test 1. With 2 bits flipped (16'hEB93) -> no lock, no tvalid, locked=0.
4. 200 random bits containing no sync pattern within MAX_ERR, then a frame -> single lock at the sync word. Two frames back-to-back, bit_valid asserted every cycle -> 16 bytes, 2 tuser, 2 tlast, frame_cnt=2.
5. Reset pulsed after byte 3 of a frame -> the following cycle all outputs are 0 and locked=0; no tlast; frame_cnt unchanged. A subsequent full frame is received correctly.
6. Payload containing 16'hEB90 inside bytes 3..4 -> emitted as data with no relock or frame split; the frame ends at byte 8.
